serial_to_parallel: RTL

Deserializer stage sitting directly downstream of the team's parallel-to-serial converter. Consumes its LSB-first serial bit stream framed by a valid strobe and rebuilds DATA_W-bit words. Completed words go to a one-entry output buffer with a valid/ready handshake. Framing and overflow errors are reported as single-cycle pulses.

---
 rtl/ser2par_pkg.sv | 23 ++
 rtl/ser2par_out_buf.sv | 60 ++++++
 rtl/serial_to_parallel.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ser2par_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
// SER2PAR_PARITY_EN adds a trailing even-parity beat to every frame.
package ser2par_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser2par_state_e;

  // Beat counter width, with headroom for the optional parity beat.
  function automatic int ser2par_cnt_w(input int data_w);
    return $clog2(data_w + 2);
  endfunction

  function automatic int ser2par_frame_len(input int data_w);
`ifdef SER2PAR_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/ser2par_out_buf.sv
// One-entry valid/ready holding register for completed words.
// It flags a dropped word with a registered one-cycle overflow pulse.
module ser2par_out_buf
  import ser2par_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;
  logic              overflow_d, overflow_q;
  logic              consume;

  assign consume = valid_q & ready_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (load_i) begin
      if (!valid_q || consume) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first deserializer: rebuilds DATA_W-bit words from a valid-framed bit stream.
// Define SER2PAR_PARITY_EN to expect and check a trailing even-parity beat per frame.
module serial_to_parallel
  import ser2par_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] parallel_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              frame_err_o,
  output logic              overflow_o,
  output logic              parity_err_o
);

  localparam int CNT_W     = ser2par_cnt_w(DATA_W);
  localparam int FRAME_LEN = ser2par_frame_len(DATA_W);

  ser2par_state_e    state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DATA_W-1:0] shreg_d, shreg_q;
  logic              frame_err_d, frame_err_q;
  logic              done;
  logic [DATA_W-1:0] word;
`ifdef SER2PAR_PARITY_EN
  logic              parity_err_d, parity_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    done        = 1'b0;
    word        = shreg_q;
`ifdef SER2PAR_PARITY_EN
    parity_err_d = 1'b0;
`else
    word[DATA_W-1] = serial_i;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          shreg_d    = '0;
          shreg_d[0] = serial_i;
          cnt_d      = CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (!valid_i) begin
          // Aborted frame: drop the partial word and flag it next cycle.
          shreg_d     = '0;
          cnt_d       = '0;
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SER2PAR_PARITY_EN
          if ((^shreg_q) == serial_i) done = 1'b1;
          else                        parity_err_d = 1'b1;
`else
          done = 1'b1;
`endif
        end else begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shreg_d[i] = serial_i;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SER2PAR_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign frame_err_o = frame_err_q;

  ser2par_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (done),
    .data_i    (word),
    .ready_i   (out_ready_i),
    .data_o    (parallel_o),
    .valid_o   (out_valid_o),
    .overflow_o(overflow_o)
  );

endmodule
